// File: rtl/risc_v_div_seq.sv
// rtl/risc_v_div_seq.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
//
// Purpose: computes the M-extension divide/remainder result one quotient bit per
// cycle beside the execute-stage ALU. The result is registered in rd and is
// qualified by a one-cycle done pulse.
//
// Ports:
//   clk              core clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            request pulse, only looked at while idle
//   abort            pipeline flush, cancels any operation in flight
//   instruction      instruction word, decoded on start
//   rs1, rs2         dividend / divisor, latched on an accepted start
//   busy             high while an operation is in flight (CALC and FIX)
//   done             one-cycle pulse, rd valid in this cycle
//   rd               result, held until the next done
//   div_decode_fault one-cycle pulse after a start carrying a non-divide instruction

module risc_v_div_seq #(
    parameter string FAST_SPECIAL = "TRUE"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic        div_decode_fault
);

    localparam logic FAST_EN = (FAST_SPECIAL == "TRUE") ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;      // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] dvsr_q, dvsr_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rd_q, rd_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    // Decode
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        dec_valid;
    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div0_in;
    logic        ovf_in;
    logic        unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    assign dec_valid = (opcode == 7'b0110011) && (funct7 == 7'b0000001) && funct3[2];
    assign op_signed = ~funct3[0];
    assign a_neg     = op_signed & rs1[31];
    assign b_neg     = op_signed & rs2[31];
    assign abs_a     = a_neg ? (32'd0 - rs1) : rs1;
    assign abs_b     = b_neg ? (32'd0 - rs2) : rs2;
    assign div0_in   = (rs2 == 32'd0);
    assign ovf_in    = op_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

    // One restoring step: the sign bit of the 33-bit trial decides the quotient bit.
    logic [32:0] trial;
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvsr_q};

    // Sign fix-up and special-case forcing
    logic [31:0] rem_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    always_comb begin
        // A bypassed divide-by-zero never iterated, so the dividend magnitude is
        // still sitting untouched in quo_q; after 32 iterations it has been
        // shifted whole into rem_q instead.
        rem_mag = (div0_q && FAST_EN) ? quo_q : rem_q;
        q_fix   = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        r_fix   = neg_rem_q ? (32'd0 - rem_mag) : rem_mag;
        if (div0_q) begin
            q_fix = 32'hFFFF_FFFF;
        end
        if (ovf_q) begin
            q_fix = 32'h8000_0000;
            r_fix = 32'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        rd_d      = rd_q;
        done_d    = 1'b0;
        fault_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (dec_valid) begin
                        cnt_d     = 5'd31;
                        rem_d     = 32'd0;
                        quo_d     = abs_a;
                        dvsr_d    = abs_b;
                        is_rem_d  = funct3[1];
                        neg_quo_d = op_signed & (rs1[31] ^ rs2[31]);
                        neg_rem_d = op_signed & rs1[31];
                        div0_d    = div0_in;
                        ovf_d     = ovf_in;
                        state_d   = (FAST_EN && (div0_in || ovf_in)) ? S_FIX : S_CALC;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                rd_d    = is_rem_q ? r_fix : q_fix;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush drops whatever was in flight without touching rd.
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            rd_d    = rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= 32'd0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign rd               = rd_q;
    assign div_decode_fault = fault_q;

endmodule
